// File: rtl/alu_share_arbiter_if.sv
// Signal bundle between the shared-ALU arbiter, its requesters and the ALU.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 7,
    parameter int OPW  = 3
);
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [OPW-1:0]      alu_op;
    logic                alu_en;
    logic [W-1:0]        alu_result;
    logic                alu_flag;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_result;
    logic                rsp_flag;

    modport slave (
        input  req, req_a, req_b, req_op, alu_result, alu_flag,
        output gnt, busy, alu_a, alu_b, alu_op, alu_en,
               rsp_valid, rsp_id, rsp_result, rsp_flag
    );

    modport master (
        output req, req_a, req_b, req_op, alu_result, alu_flag,
        input  gnt, busy, alu_a, alu_b, alu_op, alu_en,
               rsp_valid, rsp_id, rsp_result, rsp_flag
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU among NREQ requesters and
// returns each captured result tagged with the requester id. All outputs registered.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int W       = 7,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input logic               clk,
    input logic               reset_n,
    alu_share_arbiter_if.slave bus
);
    localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  last_reg, last_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            busy_reg, busy_next;
    logic [W-1:0]    alu_a_reg, alu_a_next;
    logic [W-1:0]    alu_b_reg, alu_b_next;
    logic [OPW-1:0]  alu_op_reg, alu_op_next;
    logic            alu_en_reg, alu_en_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic [IDW-1:0]  rsp_id_reg, rsp_id_next;
    logic [W-1:0]    rsp_result_reg, rsp_result_next;
    logic            rsp_flag_reg, rsp_flag_next;

    logic [W-1:0]    a_slice  [NREQ];
    logic [W-1:0]    b_slice  [NREQ];
    logic [OPW-1:0]  op_slice [NREQ];
    logic [IDW-1:0]  cand_idx [NREQ];
    logic            any_req;
    logic [IDW-1:0]  win_id;

    // cand_idx[k] is the (k+1)-th requester after the last winner, wrapped mod NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            logic [IDW:0] sum;
            assign a_slice[gi]  = bus.req_a[gi*W +: W];
            assign b_slice[gi]  = bus.req_b[gi*W +: W];
            assign op_slice[gi] = bus.req_op[gi*OPW +: OPW];
            assign sum          = {1'b0, last_reg} + (IDW+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                          : sum[IDW-1:0];
        end
    endgenerate

    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && bus.req[cand_idx[k]]) begin
                any_req = 1'b1;
                win_id  = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        cnt_next        = cnt_reg;
        gnt_next        = '0;
        alu_a_next      = '0;
        alu_b_next      = '0;
        alu_op_next     = '0;
        alu_en_next     = 1'b0;
        rsp_valid_next  = 1'b0;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_flag_next   = rsp_flag_reg;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next       = EXEC;
                    last_next        = win_id;
                    cnt_next         = CNTW'(ALU_LAT - 1);
                    gnt_next[win_id] = 1'b1;
                    alu_a_next       = a_slice[win_id];
                    alu_b_next       = b_slice[win_id];
                    alu_op_next      = op_slice[win_id];
                    alu_en_next      = 1'b1;
                end
            end
            EXEC: begin
                if (cnt_reg == '0) begin
                    state_next      = RESP;
                    rsp_valid_next  = 1'b1;
                    rsp_id_next     = last_reg;
                    rsp_result_next = bus.alu_result;
                    rsp_flag_next   = bus.alu_flag;
                end else begin
                    // The ALU drive registers double as the operand capture registers.
                    cnt_next    = cnt_reg - 1'b1;
                    alu_a_next  = alu_a_reg;
                    alu_b_next  = alu_b_reg;
                    alu_op_next = alu_op_reg;
                    alu_en_next = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_reg       <= IDW'(NREQ - 1);
            cnt_reg        <= '0;
            gnt_reg        <= '0;
            busy_reg       <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            alu_en_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_flag_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            cnt_reg        <= cnt_next;
            gnt_reg        <= gnt_next;
            busy_reg       <= busy_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= alu_op_next;
            alu_en_reg     <= alu_en_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_flag_reg   <= rsp_flag_next;
        end
    end

    assign bus.gnt        = gnt_reg;
    assign bus.busy       = busy_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_en     = alu_en_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_flag   = rsp_flag_reg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a combinational-ALU instance with a response
// scoreboard, and an ALU_LAT=3 instance driving a stub ALU that is correct only on its third cycle.
module tb_alu_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 7;
    localparam int OPW  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W), .OPW(OPW)) bus1 ();
    alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W), .OPW(OPW)) bus2 ();

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W), .OPW(OPW), .ALU_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W), .OPW(OPW), .ALU_LAT(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference ALU: {flag, result}
    function automatic logic [7:0] alu_f(input logic [6:0] a, input logic [6:0] b,
                                         input logic [2:0] op);
        logic [6:0] r;
        logic       f;
        case (op)
            3'd0:    begin r = ~a;             f = (r == 7'd0); end
            3'd1:    begin r = {a[0], a[6:1]}; f = a[0];        end
            3'd2:    {f, r} = {1'b0, a} + {1'b0, b};
            3'd3:    begin r = a & b;          f = (r == 7'd0); end
            default: begin r = a ^ b;          f = (r == 7'd0); end
        endcase
        return {f, r};
    endfunction

    logic [7:0] alu1_out, alu2_out;
    logic [1:0] en_cnt2;
    assign alu1_out         = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_op);
    assign bus1.alu_result  = alu1_out[6:0];
    assign bus1.alu_flag    = alu1_out[7];
    assign alu2_out         = alu_f(bus2.alu_a, bus2.alu_b, bus2.alu_op);
    assign bus2.alu_result  = (en_cnt2 == 2'd2) ? alu2_out[6:0] : ~alu2_out[6:0];
    assign bus2.alu_flag    = (en_cnt2 == 2'd2) ? alu2_out[7]   : ~alu2_out[7];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) en_cnt2 <= 2'd0;
        else          en_cnt2 <= bus2.alu_en ? en_cnt2 + 2'd1 : 2'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard entries: {id[1:0], flag, result[6:0]}
    logic [9:0] sb1[$];
    logic [9:0] sb_e;

    task automatic drive1(input int i, input logic [6:0] a, input logic [6:0] b,
                          input logic [2:0] op, input bit push);
        bus1.req_a[i*W +: W]      = a;
        bus1.req_b[i*W +: W]      = b;
        bus1.req_op[i*OPW +: OPW] = op;
        if (push) sb1.push_back({2'(i), alu_f(a, b, op)});
    endtask

    always @(negedge clk) begin
        if (reset_n && bus1.rsp_valid) begin
            check("sb_has_entry", 32'(sb1.size() != 0), 32'(1));
            if (sb1.size() != 0) begin
                sb_e = sb1.pop_front();
                check("rsp_id", 32'(bus1.rsp_id), 32'(sb_e[9:8]));
                check("rsp_result", 32'(bus1.rsp_result), 32'(sb_e[6:0]));
                check("rsp_flag", 32'(bus1.rsp_flag), 32'(sb_e[7]));
                $display("rsp id=%0d result=0x%0h flag=%0b", bus1.rsp_id, bus1.rsp_result,
                         bus1.rsp_flag);
            end
            check("gnt_during_rsp", 32'(bus1.gnt), 32'(0));
        end
    end

    int busy_cnt, ngr, last_t, en_cnt, rsp_at;
    logic [3:0] exp_g;
    logic [6:0] r2_result;
    logic [1:0] r2_id;

    initial begin
        bus1.req = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0;
        bus2.req = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_op = '0;

        // Reset state
        repeat (3) step();
        check("rst_gnt", 32'(bus1.gnt), 32'(0));
        check("rst_busy", 32'(bus1.busy), 32'(0));
        check("rst_alu", 32'({bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.alu_en}), 32'(0));
        check("rst_rsp", 32'({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flag}), 32'(0));
        reset_n = 1'b1;

        // Single NOT on requester 0
        drive1(0, 7'b0101010, 7'd0, 3'd0, 1'b1);
        bus1.req = 4'b0001;
        step();
        check("t1_gnt", 32'(bus1.gnt), 32'(4'b0001));
        check("t1_alu_a", 32'(bus1.alu_a), 32'(7'b0101010));
        check("t1_alu_en", 32'(bus1.alu_en), 32'(1));
        check("t1_busy", 32'(bus1.busy), 32'(1));
        bus1.req = 4'b0000;
        step();
        check("t1_rsp_valid", 32'(bus1.rsp_valid), 32'(1));
        check("t1_rsp_result", 32'(bus1.rsp_result), 32'(7'b1010101));
        check("t1_alu_en_off", 32'(bus1.alu_en), 32'(0));
        step();
        check("t1_rsp_pulse", 32'(bus1.rsp_valid), 32'(0));
        check("t1_idle", 32'(bus1.busy), 32'(0));
        check("t1_hold", 32'(bus1.rsp_result), 32'(7'b1010101));

        // Rotate right on requester 2; busy for exactly two cycles
        drive1(2, 7'b0001101, 7'd0, 3'd1, 1'b1);
        bus1.req = 4'b0100;
        step();
        busy_cnt = int'(bus1.busy);
        check("t2_gnt", 32'(bus1.gnt), 32'(4'b0100));
        bus1.req = 4'b0000;
        repeat (4) begin
            step();
            busy_cnt += int'(bus1.busy);
        end
        check("t2_busy_cycles", 32'(busy_cnt), 32'(2));
        check("t2_rsp_result", 32'(bus1.rsp_result), 32'(7'b1000110));
        check("t2_rsp_id", 32'(bus1.rsp_id), 32'(2));

        // Requester 3 alone so the pointer sits at 3 before the fairness run
        drive1(3, 7'd100, 7'd50, 3'd2, 1'b1);
        bus1.req = 4'b1000;
        step();
        check("t3_gnt", 32'(bus1.gnt), 32'(4'b1000));
        bus1.req = 4'b0000;
        repeat (3) step();

        // All four requesting: rotation 0,1,2,3 twice, 3 cycles between grants
        for (int i = 0; i < NREQ; i++)
            drive1(i, 7'(10 + i*17), 7'(5 + i*3), 3'(i), 1'b0);
        for (int k = 0; k < 8; k++)
            drive1(k % 4, 7'(10 + (k%4)*17), 7'(5 + (k%4)*3), 3'(k % 4), 1'b1);
        bus1.req = 4'b1111;
        ngr = 0;
        last_t = 0;
        for (int c = 1; c <= 60 && ngr < 8; c++) begin
            step();
            if (bus1.gnt != 4'b0000) begin
                exp_g = 4'b0001 << (ngr % 4);
                check("rr_order", 32'(bus1.gnt), 32'(exp_g));
                if (ngr > 0) check("gnt_gap", 32'(c - last_t), 32'(3));
                $display("grant %0d gnt=%b cycle=%0d", ngr, bus1.gnt, c);
                last_t = c;
                ngr++;
                if (ngr == 8) bus1.req = 4'b0000;
            end
        end
        check("rr_grant_count", 32'(ngr), 32'(8));
        bus1.req = 4'b0000;
        repeat (3) step();

        // Grant to 1, then 1 and 3 together: 3 first; 1 uses operands at its own capture
        drive1(1, 7'h33, 7'h11, 3'd3, 1'b1);
        bus1.req = 4'b0010;
        step();
        check("t4_gnt1", 32'(bus1.gnt), 32'(4'b0010));
        bus1.req = 4'b0000;
        repeat (2) step();
        drive1(3, 7'h7F, 7'h01, 3'd2, 1'b1);
        drive1(1, 7'h12, 7'h34, 3'd4, 1'b0);
        sb1.push_back({2'd1, alu_f(7'h55, 7'h0F, 3'd2)});
        bus1.req = 4'b1010;
        step();
        check("t4_gnt3_first", 32'(bus1.gnt), 32'(4'b1000));
        drive1(1, 7'h55, 7'h0F, 3'd2, 1'b0);
        bus1.req = 4'b0010;
        repeat (2) step();
        step();
        check("t4_gnt1_second", 32'(bus1.gnt), 32'(4'b0010));
        drive1(1, 7'h01, 7'h02, 3'd0, 1'b0);
        bus1.req = 4'b0000;
        repeat (3) step();

        // ALU_LAT=3 instance
        bus2.req_a[2*W +: W] = 7'b0101010;
        bus2.req_op[2*OPW +: OPW] = 3'd0;
        bus2.req = 4'b0100;
        step();
        check("t5_gnt", 32'(bus2.gnt), 32'(4'b0100));
        en_cnt = int'(bus2.alu_en);
        rsp_at = 0;
        r2_result = '0;
        r2_id = '0;
        bus2.req = 4'b0000;
        for (int k = 2; k <= 7; k++) begin
            step();
            en_cnt += int'(bus2.alu_en);
            if (bus2.rsp_valid && rsp_at == 0) begin
                rsp_at = k;
                r2_result = bus2.rsp_result;
                r2_id = bus2.rsp_id;
            end
        end
        check("t5_alu_en_cycles", 32'(en_cnt), 32'(3));
        check("t5_rsp_latency", 32'(rsp_at), 32'(4));
        check("t5_rsp_result", 32'(r2_result), 32'(7'b1010101));
        check("t5_rsp_id", 32'(r2_id), 32'(2));

        // Reset in the middle of EXEC aborts silently and restores the pointer
        drive1(2, 7'h11, 7'h22, 3'd2, 1'b0);
        bus1.req = 4'b0100;
        step();
        check("t6_in_exec", 32'(bus1.alu_en), 32'(1));
        #2 reset_n = 1'b0;
        bus1.req = 4'b0000;
        #1;
        check("t6_rst_gnt_busy", 32'({bus1.gnt, bus1.busy}), 32'(0));
        check("t6_rst_alu", 32'({bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.alu_en}), 32'(0));
        check("t6_rst_rsp", 32'({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flag}), 32'(0));
        step();
        reset_n = 1'b1;
        repeat (3) begin
            step();
            check("t6_no_rsp", 32'(bus1.rsp_valid), 32'(0));
        end
        drive1(0, 7'h40, 7'h40, 3'd2, 1'b1);
        bus1.req = 4'b1101;
        step();
        check("t6_gnt0_first", 32'(bus1.gnt), 32'(4'b0001));
        bus1.req = 4'b0000;
        repeat (3) step();

        check("sb_drained", 32'(sb1.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
